// File: rtl/zap_fetch_main_pkg.sv
// -----------------------------------------------------------------------------
// zap_fetch_main_pkg
// Definitions shared by the fetch stage and predecode:
//   - 2-bit branch-prediction state encodings (SNT/WNT/WT/ST)
//   - the per-cycle stall/clear priority resolution used by the output regs
//   - the saturating-counter training function
//   - the predictor-table init FSM state type
// -----------------------------------------------------------------------------
package zap_fetch_main_pkg;

    localparam logic [1:0] BP_SNT = 2'd0;
    localparam logic [1:0] BP_WNT = 2'd1;
    localparam logic [1:0] BP_WT  = 2'd2;
    localparam logic [1:0] BP_ST  = 2'd3;

    // What the pipeline output registers do in a given cycle.
    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_HOLD  = 2'd1,
        ACT_CLEAR = 2'd2
    } fetch_act_e;

    // Predictor table init FSM.
    typedef enum logic {
        BP_FSM_INIT = 1'b0,
        BP_FSM_RUN  = 1'b1
    } bp_fsm_e;

    // Stall/clear priority, first match wins. Reset is handled by the caller.
    function automatic fetch_act_e fetch_action(
        input logic code_stall,
        input logic clear_wb,
        input logic data_stall,
        input logic clear_alu,
        input logic stall_shifter,
        input logic stall_issue,
        input logic stall_decode,
        input logic clear_decode
    );
        fetch_act_e act;
        if (code_stall) begin
            act = ACT_HOLD;
        end else if (clear_wb) begin
            act = ACT_CLEAR;
        end else if (data_stall) begin
            act = ACT_HOLD;
        end else if (clear_alu) begin
            act = ACT_CLEAR;
        end else if (stall_shifter) begin
            act = ACT_HOLD;
        end else if (stall_issue) begin
            act = ACT_HOLD;
        end else if (stall_decode) begin
            act = ACT_HOLD;
        end else if (clear_decode) begin
            act = ACT_CLEAR;
        end else begin
            act = ACT_LOAD;
        end
        return act;
    endfunction

    // Two-bit saturating counter step.
    function automatic logic [1:0] bp_saturate(input logic [1:0] state, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            if (state == BP_ST) begin
                nxt = BP_ST;
            end else begin
                nxt = state + 2'd1;
            end
        end else begin
            if (state == BP_SNT) begin
                nxt = BP_SNT;
            end else begin
                nxt = state - 2'd1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/zap_branch_state_ram.sv
// -----------------------------------------------------------------------------
// zap_branch_state_ram
// BP_ENTRIES x 2-bit branch-state table with one asynchronous read port and
// one synchronous write port, plus the init FSM that sweeps every entry to
// WNT after reset. Only built when ZAP_FETCH_BP_EN is defined.
// Ports:
//   clk_i        core clock
//   reset_i      synchronous active-high reset; restarts the init sweep
//   rd_idx_i     lookup index (async read)
//   rd_state_o   lookup result; WNT while the sweep is running
//   upd_valid_i  training strobe (dropped during the sweep)
//   upd_idx_i    index of the resolved branch
//   upd_taken_i  resolved outcome
// -----------------------------------------------------------------------------
module zap_branch_state_ram
    import zap_fetch_main_pkg::*;
#(
    parameter int BP_ENTRIES = 1024,
    parameter int IDX_W      = $clog2(BP_ENTRIES)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_state_o,
    input  logic             upd_valid_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BP_ENTRIES - 1);

    bp_fsm_e          state_q;
    logic [IDX_W-1:0] init_idx_q;
    logic [1:0]       mem_q [BP_ENTRIES];

    logic             wr_en_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [1:0]       wr_data_s;

    // Init FSM: sweep indices 0..BP_ENTRIES-1, then run forever until reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= BP_FSM_INIT;
            init_idx_q <= {IDX_W{1'b0}};
        end else begin
            case (state_q)
                BP_FSM_INIT: begin
                    init_idx_q <= init_idx_q + IDX_W'(1);
                    if (init_idx_q == LAST_IDX) begin
                        state_q <= BP_FSM_RUN;
                    end else begin
                        state_q <= BP_FSM_INIT;
                    end
                end
                BP_FSM_RUN: begin
                    state_q <= BP_FSM_RUN;
                end
                default: begin
                    state_q    <= BP_FSM_INIT;
                    init_idx_q <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Write-port select: the init sweep owns the port; training only in RUN.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = init_idx_q;
        wr_data_s = BP_WNT;
        if (reset_i) begin
            wr_en_s = 1'b0;
        end else if (state_q == BP_FSM_INIT) begin
            wr_en_s = 1'b1;
        end else if (upd_valid_i) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = upd_idx_i;
            wr_data_s = bp_saturate(mem_q[upd_idx_i], upd_taken_i);
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Table storage; the write lands at the edge, so a same-cycle lookup
    // still sees the old value.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_q[wr_idx_s] <= wr_data_s;
        end
    end

    // Entries are undefined until swept, so report WNT during the sweep.
    assign rd_state_o = (state_q == BP_FSM_INIT) ? BP_WNT : mem_q[rd_idx_i];

endmodule

// File: rtl/zap_fetch_main.sv
// -----------------------------------------------------------------------------
// zap_fetch_main
// Fetch stage output registers. Captures the I-cache word with its PC, PC+8
// (PC+4 in Thumb) and abort flag, and attaches a 2-bit branch-prediction state
// looked up by PC. Output registers follow a fixed stall/clear priority chain.
// Configuration macro: ZAP_FETCH_BP_EN
//   defined   : predictor table (zap_branch_state_ram) is built and trained
//   undefined : no table; loads attach constant WNT, update inputs ignored
// Ports:
//   i_clk, i_reset                    clock, synchronous active-high reset
//   i_code_stall .. i_clear_from_decode  stall/clear controls
//   i_cpu_mode_t                      Thumb state (selects +4 instead of +8)
//   i_pc_ff, i_instruction, i_valid, i_instr_abort   fetch response
//   i_bp_upd_valid/pc/taken           predictor training from the ALU
//   o_instruction_ff, o_valid_ff, o_instr_abort_ff, o_pc_ff,
//   o_pc_plus_8_ff, o_taken_ff        registered outputs to predecode
// -----------------------------------------------------------------------------
module zap_fetch_main
    import zap_fetch_main_pkg::*;
#(
    parameter int BP_ENTRIES = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_code_stall,
    input  logic        i_clear_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_clear_from_alu,
    input  logic        i_stall_from_shifter,
    input  logic        i_stall_from_issue,
    input  logic        i_stall_from_decode,
    input  logic        i_clear_from_decode,
    input  logic        i_cpu_mode_t,
    input  logic [31:0] i_pc_ff,
    input  logic [31:0] i_instruction,
    input  logic        i_valid,
    input  logic        i_instr_abort,
    input  logic        i_bp_upd_valid,
    input  logic [31:0] i_bp_upd_pc,
    input  logic        i_bp_upd_taken,
    output logic [31:0] o_instruction_ff,
    output logic        o_valid_ff,
    output logic        o_instr_abort_ff,
    output logic [31:0] o_pc_ff,
    output logic [31:0] o_pc_plus_8_ff,
    output logic [1:0]  o_taken_ff
);

    localparam int IDX_W = $clog2(BP_ENTRIES);

    logic [1:0]  lookup_s;
    fetch_act_e  act_s;

    logic [31:0] instruction_q, instruction_d;
    logic        valid_q, valid_d;
    logic        abort_q, abort_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus_8_q, pc_plus_8_d;
    logic [1:0]  taken_q, taken_d;

`ifdef ZAP_FETCH_BP_EN
    logic [IDX_W-1:0] rd_idx_s;
    logic [IDX_W-1:0] upd_idx_s;
    logic             unused_s;

    // Halfword-granular index so Thumb branches get their own entries.
    assign rd_idx_s  = i_pc_ff[IDX_W:1];
    assign upd_idx_s = i_bp_upd_pc[IDX_W:1];
    assign unused_s  = ^i_bp_upd_pc;

    zap_branch_state_ram #(
        .BP_ENTRIES (BP_ENTRIES),
        .IDX_W      (IDX_W)
    ) u_branch_state_ram (
        .clk_i       (i_clk),
        .reset_i     (i_reset),
        .rd_idx_i    (rd_idx_s),
        .rd_state_o  (lookup_s),
        .upd_valid_i (i_bp_upd_valid),
        .upd_idx_i   (upd_idx_s),
        .upd_taken_i (i_bp_upd_taken)
    );
`else
    logic unused_s;

    assign lookup_s = BP_WNT;
    assign unused_s = ^{i_bp_upd_valid, i_bp_upd_pc, i_bp_upd_taken};
`endif

    assign act_s = fetch_action(i_code_stall, i_clear_from_writeback, i_data_stall,
                                i_clear_from_alu, i_stall_from_shifter,
                                i_stall_from_issue, i_stall_from_decode,
                                i_clear_from_decode);

    // Next-state for the output registers; clears keep PC/instruction.
    always_comb begin
        instruction_d = instruction_q;
        valid_d       = valid_q;
        abort_d       = abort_q;
        pc_d          = pc_q;
        pc_plus_8_d   = pc_plus_8_q;
        taken_d       = taken_q;
        case (act_s)
            ACT_LOAD: begin
                valid_d       = i_valid;
                abort_d       = i_valid & i_instr_abort;
                instruction_d = (i_valid & ~i_instr_abort) ? i_instruction : 32'd0;
                pc_d          = i_pc_ff;
                pc_plus_8_d   = i_pc_ff + (i_cpu_mode_t ? 32'd4 : 32'd8);
                taken_d       = lookup_s;
            end
            ACT_CLEAR: begin
                valid_d = 1'b0;
                abort_d = 1'b0;
                taken_d = BP_SNT;
            end
            ACT_HOLD: begin
                valid_d = valid_q;
            end
            default: begin
                valid_d = valid_q;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            instruction_q <= 32'd0;
            valid_q       <= 1'b0;
            abort_q       <= 1'b0;
            pc_q          <= 32'd0;
            pc_plus_8_q   <= 32'd0;
            taken_q       <= 2'd0;
        end else begin
            instruction_q <= instruction_d;
            valid_q       <= valid_d;
            abort_q       <= abort_d;
            pc_q          <= pc_d;
            pc_plus_8_q   <= pc_plus_8_d;
            taken_q       <= taken_d;
        end
    end

    assign o_instruction_ff = instruction_q;
    assign o_valid_ff       = valid_q;
    assign o_instr_abort_ff = abort_q;
    assign o_pc_ff          = pc_q;
    assign o_pc_plus_8_ff   = pc_plus_8_q;
    assign o_taken_ff       = taken_q;

endmodule

// File: tb/tb_zap_fetch_main.sv
// -----------------------------------------------------------------------------
// tb_zap_fetch_main
// Scoreboard bench: each driven cycle pushes the expected register contents
// computed from a reference model; the following sample pops and compares.
// -----------------------------------------------------------------------------
module tb_zap_fetch_main;

    localparam int BP_ENTRIES = 1024;

    logic        i_clk = 1'b0;
    logic        i_reset, i_code_stall, i_clear_from_writeback, i_data_stall;
    logic        i_clear_from_alu, i_stall_from_shifter, i_stall_from_issue;
    logic        i_stall_from_decode, i_clear_from_decode, i_cpu_mode_t;
    logic [31:0] i_pc_ff, i_instruction, i_bp_upd_pc;
    logic        i_valid, i_instr_abort, i_bp_upd_valid, i_bp_upd_taken;
    logic [31:0] o_instruction_ff, o_pc_ff, o_pc_plus_8_ff;
    logic        o_valid_ff, o_instr_abort_ff;
    logic [1:0]  o_taken_ff;

    always #5 i_clk = ~i_clk;

    zap_fetch_main #(.BP_ENTRIES(BP_ENTRIES)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_code_stall(i_code_stall),
        .i_clear_from_writeback(i_clear_from_writeback), .i_data_stall(i_data_stall),
        .i_clear_from_alu(i_clear_from_alu), .i_stall_from_shifter(i_stall_from_shifter),
        .i_stall_from_issue(i_stall_from_issue), .i_stall_from_decode(i_stall_from_decode),
        .i_clear_from_decode(i_clear_from_decode), .i_cpu_mode_t(i_cpu_mode_t),
        .i_pc_ff(i_pc_ff), .i_instruction(i_instruction), .i_valid(i_valid),
        .i_instr_abort(i_instr_abort), .i_bp_upd_valid(i_bp_upd_valid),
        .i_bp_upd_pc(i_bp_upd_pc), .i_bp_upd_taken(i_bp_upd_taken),
        .o_instruction_ff(o_instruction_ff), .o_valid_ff(o_valid_ff),
        .o_instr_abort_ff(o_instr_abort_ff), .o_pc_ff(o_pc_ff),
        .o_pc_plus_8_ff(o_pc_plus_8_ff), .o_taken_ff(o_taken_ff)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic        valid;
        logic        abort;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [1:0]  taken;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       model_q = '0;
    logic [1:0] tbl [BP_ENTRIES];
    bit         in_init = 1'b1;
    int         init_cnt = 0;
    int         tests_run = 0;
    int         tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[10:1]);
    endfunction

    task automatic idle();
        i_reset = 1'b0; i_code_stall = 1'b0; i_clear_from_writeback = 1'b0;
        i_data_stall = 1'b0; i_clear_from_alu = 1'b0; i_stall_from_shifter = 1'b0;
        i_stall_from_issue = 1'b0; i_stall_from_decode = 1'b0; i_clear_from_decode = 1'b0;
        i_cpu_mode_t = 1'b0; i_pc_ff = 32'd0; i_instruction = 32'd0; i_valid = 1'b0;
        i_instr_abort = 1'b0; i_bp_upd_valid = 1'b0; i_bp_upd_pc = 32'd0; i_bp_upd_taken = 1'b0;
    endtask

    // One clock: model the cycle, push expectation, clock, pop and compare.
    task automatic step(input string tag);
        exp_t       nx;
        exp_t       got_e;
        logic [1:0] look;
        int         k;
`ifdef ZAP_FETCH_BP_EN
        look = in_init ? 2'd1 : tbl[idx_of(i_pc_ff)];
`else
        look = 2'd1;
`endif
        nx = model_q;
        if (i_reset) begin
            nx = '0;
        end else if (i_code_stall) begin
            nx = model_q;
        end else if (i_clear_from_writeback) begin
            nx.valid = 1'b0; nx.abort = 1'b0; nx.taken = 2'd0;
        end else if (i_data_stall) begin
            nx = model_q;
        end else if (i_clear_from_alu) begin
            nx.valid = 1'b0; nx.abort = 1'b0; nx.taken = 2'd0;
        end else if (i_stall_from_shifter || i_stall_from_issue || i_stall_from_decode) begin
            nx = model_q;
        end else if (i_clear_from_decode) begin
            nx.valid = 1'b0; nx.abort = 1'b0; nx.taken = 2'd0;
        end else begin
            nx.valid = i_valid;
            nx.abort = i_valid && i_instr_abort;
            nx.instr = (i_valid && !i_instr_abort) ? i_instruction : 32'd0;
            nx.pc    = i_pc_ff;
            nx.pc8   = i_pc_ff + (i_cpu_mode_t ? 32'd4 : 32'd8);
            nx.taken = look;
        end
        model_q = nx;
        sb_q.push_back(nx);
`ifdef ZAP_FETCH_BP_EN
        if (i_reset) begin
            in_init = 1'b1; init_cnt = 0;
        end else if (in_init) begin
            tbl[init_cnt] = 2'd1;
            init_cnt++;
            if (init_cnt == BP_ENTRIES) in_init = 1'b0;
        end else if (i_bp_upd_valid) begin
            k = idx_of(i_bp_upd_pc);
            if (i_bp_upd_taken) begin
                if (tbl[k] != 2'd3) tbl[k] = tbl[k] + 2'd1;
            end else begin
                if (tbl[k] != 2'd0) tbl[k] = tbl[k] - 2'd1;
            end
        end
`else
        k = 0;
`endif
        @(posedge i_clk);
        @(negedge i_clk);
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            got_e = sb_q.pop_front();
            check_eq({tag, "_valid"}, {31'd0, o_valid_ff}, {31'd0, got_e.valid});
            check_eq({tag, "_abort"}, {31'd0, o_instr_abort_ff}, {31'd0, got_e.abort});
            check_eq({tag, "_instr"}, o_instruction_ff, got_e.instr);
            check_eq({tag, "_pc"}, o_pc_ff, got_e.pc);
            check_eq({tag, "_pc8"}, o_pc_plus_8_ff, got_e.pc8);
            check_eq({tag, "_taken"}, {30'd0, o_taken_ff}, {30'd0, got_e.taken});
        end
    endtask

    task automatic load(input string tag, input logic [31:0] pc, input logic [31:0] w, input logic t);
        idle();
        i_pc_ff = pc; i_instruction = w; i_valid = 1'b1; i_cpu_mode_t = t;
        step(tag);
    endtask

    task automatic train(input logic [31:0] pc, input logic taken);
        idle();
        i_bp_upd_valid = 1'b1; i_bp_upd_pc = pc; i_bp_upd_taken = taken;
        step("train");
    endtask

    logic [31:0] pc_set [4];

    initial begin
        pc_set[0] = 32'h0000_0200; pc_set[1] = 32'h0000_0202;
        pc_set[2] = 32'h0000_0204; pc_set[3] = 32'h0000_0A00;

        // Reset: all outputs zero.
        idle(); i_reset = 1'b1; i_pc_ff = 32'h1234_5678; i_valid = 1'b1;
        step("reset");
        step("reset2");

        // Init sweep with traffic; a training strobe during it is dropped.
        for (int n = 0; n < BP_ENTRIES; n++) begin
            idle();
            i_pc_ff = $urandom; i_instruction = $urandom; i_valid = 1'b1;
            if (n == 10) begin
                i_bp_upd_valid = 1'b1; i_bp_upd_pc = 32'h40; i_bp_upd_taken = 1'b1;
            end
            step("init");
        end
        load("post_init_40", 32'h40, 32'h1111_2222, 1'b0);
        load("post_init_rand", $urandom, 32'h3333_4444, 1'b0);

        // Basic ARM load and Thumb wrap.
        load("arm_load", 32'h100, 32'hEA00_0004, 1'b0);
        load("thumb_wrap", 32'hFFFF_FFFE, 32'h0000_46C0, 1'b1);

        // Training: saturate up, check neighbour index, saturate down.
        for (int n = 0; n < 3; n++) train(32'h200, 1'b1);
        load("bp_up_200", 32'h200, 32'hA, 1'b0);
        load("bp_202", 32'h202, 32'hB, 1'b0);
        train(32'h200, 1'b1);
        load("bp_sat_hi", 32'h200, 32'hC, 1'b0);
        for (int n = 0; n < 4; n++) train(32'h200, 1'b0);
        load("bp_down_200", 32'h200, 32'hD, 1'b0);
        train(32'h200, 1'b0);
        load("bp_sat_lo", 32'h200, 32'hE, 1'b0);

        // Code stall beats clear_alu; then clear_alu alone.
        load("pre_stall", 32'h300, 32'hDEAD_BEEF, 1'b0);
        idle(); i_code_stall = 1'b1; i_clear_from_alu = 1'b1; i_valid = 1'b1; i_pc_ff = 32'h400;
        step("code_stall");
        idle(); i_clear_from_alu = 1'b1; i_valid = 1'b1; i_pc_ff = 32'h400;
        step("clear_alu");

        // Abort zeroes the instruction word.
        idle(); i_valid = 1'b1; i_instr_abort = 1'b1; i_pc_ff = 32'h500; i_instruction = 32'hFFFF_FFFF;
        step("abort");

        // Decode stall beats decode clear.
        load("pre_dec", 32'h600, 32'h1234_0000, 1'b0);
        idle(); i_stall_from_decode = 1'b1; i_clear_from_decode = 1'b1; i_valid = 1'b1; i_pc_ff = 32'h700;
        step("dec_stall");
        idle(); i_clear_from_decode = 1'b1; i_valid = 1'b1; i_pc_ff = 32'h700;
        step("dec_clear");

        // Random mix of controls, lookups and training on colliding PCs.
        for (int n = 0; n < 400; n++) begin
            idle();
            i_code_stall           = ($urandom_range(9) == 0);
            i_clear_from_writeback = ($urandom_range(9) == 0);
            i_data_stall           = ($urandom_range(9) == 0);
            i_clear_from_alu       = ($urandom_range(9) == 0);
            i_stall_from_shifter   = ($urandom_range(9) == 0);
            i_stall_from_issue     = ($urandom_range(9) == 0);
            i_stall_from_decode    = ($urandom_range(9) == 0);
            i_clear_from_decode    = ($urandom_range(9) == 0);
            i_cpu_mode_t           = $urandom_range(1);
            i_pc_ff                = ($urandom_range(3) == 0) ? $urandom : pc_set[$urandom_range(3)];
            i_instruction          = $urandom;
            i_valid                = ($urandom_range(3) != 0);
            i_instr_abort          = ($urandom_range(5) == 0);
            i_bp_upd_valid         = $urandom_range(1);
            i_bp_upd_pc            = pc_set[$urandom_range(3)];
            i_bp_upd_taken         = $urandom_range(1);
            step("rand");
        end

        // Reset mid-run restarts the sweep; lookups report WNT again.
        idle(); i_reset = 1'b1;
        step("reset_mid");
        load("after_reset_200", 32'h200, 32'h55, 1'b0);
        for (int n = 0; n < 4; n++) train(32'h204, 1'b1);
        load("after_reset_204", 32'h204, 32'h66, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
